// File: rtl/piso_unload_reg.sv
// Parallel-in, serial-out unload register: captures a word on load and
// presents it one bit per cycle with valid, back-pressure hold and a done pulse.
module piso_unload_reg #(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] inp,
  input  logic         hold,
  output logic         sout,
  output logic         sval,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  shr, shr_n;
  logic [CW-1:0] cnt, cnt_n;

  // State, shift register and bit counter
  always_ff @(posedge ck) begin
    if (rst) begin
      state <= ST_IDLE;
      shr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      shr   <= shr_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state and output decode; sval follows hold combinationally in SHIFT
  always_comb begin
    state_n = state;
    shr_n   = shr;
    cnt_n   = cnt;
    sout    = 1'b0;
    sval    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          shr_n   = inp;
          cnt_n   = '0;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        sout = MSB_FIRST ? shr[N-1] : shr[0];
        sval = !hold;
        if (!hold) begin
          shr_n = MSB_FIRST ? {shr[N-2:0], 1'b0} : {1'b0, shr[N-1:1]};
          // Counter saturates on the last bit; the exit to DONE happens there
          if (cnt == LAST) begin
            state_n = ST_DONE;
          end else begin
            cnt_n = CW'(cnt + 1'b1);
          end
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (load) begin
          shr_n   = inp;
          cnt_n   = '0;
          state_n = ST_SHIFT;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_unload_reg.sv
// Directed + random bench for piso_unload_reg; MSB-first and LSB-first
// instances share stimulus and are checked against a bit-queue model.
module tb_piso_unload_reg;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] inp = 4'h0;
  logic       hold = 1'b0;

  logic sout_m, sval_m, busy_m, done_m;
  logic sout_l, sval_l, busy_l, done_l;

  int total = 0;
  int bad   = 0;

  // Reference model: pending bits in transmit order, plus a done flag
  bit qm[$];
  bit ql[$];
  bit donef = 1'b0;

  always #5 ck = ~ck;

  piso_unload_reg #(.N(4), .MSB_FIRST(1'b1)) dut_m (
    .ck(ck), .rst(rst), .load(load), .inp(inp), .hold(hold),
    .sout(sout_m), .sval(sval_m), .busy(busy_m), .done(done_m)
  );

  piso_unload_reg #(.N(4), .MSB_FIRST(1'b0)) dut_l (
    .ck(ck), .rst(rst), .load(load), .inp(inp), .hold(hold),
    .sout(sout_l), .sval(sval_l), .busy(busy_l), .done(done_l)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance model at the edge
  task automatic cyc(input logic r, input logic l, input logic [3:0] d, input logic h);
    bit am, al;
    rst = r; load = l; inp = d; hold = h;
    #1;
    am = (qm.size() > 0);
    al = (ql.size() > 0);
    check1("msb_busy", busy_m, am);
    check1("msb_sval", sval_m, am && !h);
    check1("msb_sout", sout_m, am ? qm[0] : 1'b0);
    check1("msb_done", done_m, donef);
    check1("lsb_busy", busy_l, al);
    check1("lsb_sval", sval_l, al && !h);
    check1("lsb_sout", sout_l, al ? ql[0] : 1'b0);
    check1("lsb_done", done_l, donef);
    @(posedge ck);
    if (r) begin
      qm.delete();
      ql.delete();
      donef = 1'b0;
    end else if (am) begin
      donef = 1'b0;
      if (!h) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
        if (qm.size() == 0) donef = 1'b1;
      end
    end else begin
      donef = 1'b0;
      if (l) begin
        for (int i = 3; i >= 0; i--) qm.push_back(d[i]);
        for (int i = 0; i <= 3; i++) ql.push_back(d[i]);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    // Bring both instances out of X before any comparison
    rst = 1'b1;
    @(posedge ck);
    #1;

    // Reset has priority over load
    cyc(1'b1, 1'b1, 4'hF, 1'b0);
    cyc(1'b1, 1'b1, 4'hF, 1'b0);
    idle(3);

    // Basic word, no hold (LSB instance sees 0001 later)
    cyc(1'b0, 1'b1, 4'b1011, 1'b0);
    idle(6);

    // Hold in the second and third bit cycles
    cyc(1'b0, 1'b1, 4'b1011, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b1);
    cyc(1'b0, 1'b0, 4'h0, 1'b1);
    idle(6);

    // Load while busy is ignored
    cyc(1'b0, 1'b1, 4'b1011, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'b0100, 1'b0);
    idle(6);

    // Back-to-back: second load lands in the DONE cycle
    cyc(1'b0, 1'b1, 4'hA, 1'b0);
    idle(4);
    cyc(1'b0, 1'b1, 4'h5, 1'b0);
    idle(6);

    // Hold on the last bit delays DONE
    cyc(1'b0, 1'b1, 4'h9, 1'b0);
    idle(3);
    cyc(1'b0, 1'b0, 4'h0, 1'b1);
    cyc(1'b0, 1'b0, 4'h0, 1'b1);
    idle(4);

    // Reset in the second bit cycle, then a fresh word
    cyc(1'b0, 1'b1, 4'hC, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    idle(2);
    cyc(1'b0, 1'b1, 4'h3, 1'b0);
    idle(6);

    // LSB-first visible bit order check word
    cyc(1'b0, 1'b1, 4'b0001, 1'b0);
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
          4'($urandom), ($urandom_range(0, 3) == 0));
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_unload_reg.md
# piso_unload_reg

Parallel-in, serial-out unload register: the reader side of the team's parallel-load register. It captures an N-bit word on a load request and presents it one bit per cycle on a serial output with a valid flag and a back-pressure hold. It pulses `done` once the last bit has been consumed. It sits between a parallel-loaded register bank and any bit-serial consumer (serial link, shift chain, debug port).

## Interface
Parameters:
- `N`, 4: word width in bits (N ≥ 2).
- `MSB_FIRST`, 1: 1 = bit N-1 is sent first; 0 = bit 0 is sent first.

Ports:
- `ck`, in, 1: clock; all state changes on rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `load`, in, 1: request to capture `inp`. Accepted only when not busy.
- `inp`, in, N: parallel word to serialize.
- `hold`, in, 1: consumer stall. While high, the current bit is not consumed.
- `sout`, out, 1: current serial bit.
- `sval`, out, 1: `sout` is valid and is consumed at the next edge.
- `busy`, out, 1: a word is being shifted; `load` is ignored.
- `done`, out, 1: one-cycle pulse after the last bit is consumed.

## Operation
- Internal state:
  - N-bit shift register `shr`.
  - Bit counter `cnt` of width clog2(N), range 0..N-1.
  - State machine with states IDLE, SHIFT, DONE.
- IDLE:
  - `busy`=0, `sval`=0, `done`=0.
  - `load`=1: `shr`←`inp`, `cnt`←0, next state SHIFT.
- SHIFT:
  - `busy`=1.
  - `sout` = `shr[N-1]` if MSB_FIRST=1, else `shr[0]`.
  - `sval` = !`hold` (combinational from `hold`).
  - `hold`=1: `shr`, `cnt` and state are frozen, and `sout` stays stable.
  - `hold`=0: bit consumed. `shr` shifts toward the output end (zero fill) and `cnt` increments.
  - If `cnt`==N-1 and `hold`=0, the next state is DONE.
  - `load` during SHIFT is ignored; `shr` is not overwritten.
- DONE (exactly one cycle):
  - `done`=1, `busy`=0, `sval`=0.
  - `load`=1 is accepted exactly as in IDLE, with next state SHIFT. This gives back-to-back words with a one-cycle gap.
  - Otherwise the next state is IDLE.
- `sout` outside SHIFT: 0 (gated).
- Counter arithmetic: `cnt` never wraps past N-1. The DONE transition happens on that value.

## Timing
- Reset:
  - `rst`=1 at an edge forces IDLE, `shr`=0, `cnt`=0.
  - In the following cycle: `sout`=0, `sval`=0, `busy`=0, `done`=0.
  - `rst` has priority over `load` and `hold`.
  - Reset mid-SHIFT discards the word with no `done` pulse.
- Load at edge k (no hold):
  - Cycles k+1 … k+N: `sval`=1, bits presented in order.
  - Cycle k+N+1: `done`=1.
  - Load-to-done latency is N+1 cycles. Each held cycle adds one cycle.
- A bit is transferred on an edge where `sval`=1 (that is, SHIFT and `hold`=0).
- `hold` may assert or deassert on any cycle, including the first and last bit cycles. If `hold` is high in the last bit cycle, the DONE transition is delayed until it drops.
- `hold` is ignored outside SHIFT.
- Maximum throughput: one word per N+1 cycles.

## Test plan
- **Reset priority:** `rst`=1 with `load`=1, `inp`=4'hF for 2 cycles, then `rst`=0 and `load`=0 → all outputs 0, `busy`=0, and no SHIFT entered.
- **Basic MSB-first:** N=4, load 4'b1011 at edge k, `hold`=0 → `sout` = 1,0,1,1 in cycles k+1..k+4 with `sval`=1 and `busy`=1; `done`=1 only in k+5; `busy`=0 from k+5.
- **Hold stall:** load 4'b1011, `hold`=1 in cycles k+2 and k+3 → `sout` stays 0 and `sval`=0 in both cycles; sequence completes as 1,0,1,1; `done` in k+7.
- **Load while busy:** load 4'b1011, then `load`=1 with `inp`=4'b0100 in cycle k+2 → the output sequence is still 1,0,1,1; the second word is never emitted.
- **Back-to-back and reset mid-word:**
  - Load 4'hA, then `load`=1 with 4'h5 during the DONE cycle → 1,0,1,0 then 0,1,0,1, with exactly one non-valid cycle between words.
  - Assert `rst` in the second bit cycle of a word → IDLE next cycle with no `done` pulse; a subsequent load of 4'h3 serializes as 0,0,1,1.
- **LSB-first variant:** MSB_FIRST=0, load 4'b0001 → `sout` = 1,0,0,0, then `done`.
